// File: rtl/mul_sched_if.sv
// Request/response bundle between NREQ requesters and the shared multiplier
// scheduler. Operands for requester i live at [i*W +: W] of req_a/req_b.
//
// Handshake: a request transfers on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready is at most one-hot and may depend
// combinationally on req_valid in the same cycle. A requester may lower
// req_valid before it is accepted. Operands are sampled only on the transfer
// edge. rsp_valid is a one-cycle, one-hot strobe. It carries no back-pressure:
// the response is simply offered to the requester that was granted.
interface mul_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 64
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_y;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multicycle multiplier between NREQ
// requesters. Operands are registered onto mul_a/mul_b at the grant and are
// held there. The product is captured after a fixed LAT-cycle count. The
// multiplier's own done flag is not used, because it does not fire when the
// same operands are presented twice.
module mul_sched #(
  parameter int NREQ = 4,
  parameter int W    = 64,
  parameter int LAT  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_sched_if.slave     bus,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y,
  output logic           busy,
  output logic           dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cur_id;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   grant_id;
  logic            grant_any;
  logic            hs;
  logic            done;
  logic [PW-1:0]   ptr_after;

  // Winner search: scan from ptr upward, the first valid requester wins.
  // The loop runs backwards so the last assignment is the highest priority.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = PW'(idx);
      end
    end
  end

  assign hs        = (state == IDLE) && grant_any;
  assign done      = (state == BUSY) && (cnt == '0);
  assign ptr_after = (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // Ready is offered only to the winner, only when idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (hs && rst_n) begin
      bus.req_ready = NREQ'(1) << grant_id;
    end
  end

  // Next state: leave IDLE on a handshake, return once the count expires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: latch operands on the handshake, count down, capture the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      cur_id        <= '0;
      cnt           <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      bus.rsp_y     <= '0;
      bus.rsp_valid <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (hs) begin
        mul_a  <= bus.req_a[int'(grant_id)*W +: W];
        mul_b  <= bus.req_b[int'(grant_id)*W +: W];
        cur_id <= grant_id;
        cnt    <= CW'(LAT - 1);
        ptr    <= ptr_after;
      end else if (done) begin
        bus.rsp_y     <= mul_y;
        bus.rsp_valid <= NREQ'(1) << cur_id;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy      = (state == BUSY);
  assign dbg_state = state;

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Round-robin scheduler that shares one multicycle 64x64 multiplier between NREQ requesters.
- Accepts one operand pair at a time through a valid/ready handshake and drives the multiplier operand inputs.
- Holds those operands stable for LAT cycles, then captures the 128-bit product and returns it to the granted requester.
- Timing is counter-based. The multiplier's own done flag is ignored because it does not fire for repeated identical operands.

Parameters:
NREQ, 4, number of requesters (>=2)
W, 64, operand width; product is 2*W
LAT, 5, cycles the operands must be held before the product is valid (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
rsp_valid  out  NREQ  one-cycle one-hot result strobe
rsp_y  out  2*W  product, held until next capture
mul_a  out  W  multiplier operand A (registered)
mul_b  out  W  multiplier operand B (registered)
mul_y  in  2*W  multiplier product
busy  out  1  high while state is BUSY

Behaviour:
- Reset (async, rst_n=0) clears:
  - state=IDLE, rr pointer ptr=0, cnt=0, cur_id=0.
  - mul_a=0, mul_b=0, rsp_y=0, rsp_valid=0, busy=0.
  - req_ready=0 while rst_n is low.
- FSM has 2 states: IDLE and BUSY.
- IDLE:
  - Winner g is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 is combinational, in the same cycle as req_valid. All other req_ready bits are 0.
  - When no requests are pending, req_ready=0.
- Handshake in IDLE, cycle T:
  - mul_a<=req_a[g], mul_b<=req_b[g], cur_id<=g, cnt<=LAT-1, ptr<=(g+1) mod NREQ, state<=BUSY.
- BUSY:
  - req_ready=0 for all requesters. Requests wait; they are not dropped by the scheduler.
  - Each cycle with cnt!=0: cnt<=cnt-1.
  - In the cycle with cnt==0: rsp_y<=mul_y, rsp_valid<=onehot(cur_id), state<=IDLE.
- Latency and throughput:
  - Handshake in cycle T gives rsp_valid high in cycle T+LAT+1 for exactly one cycle.
  - A new grant may occur in that same response cycle, so throughput is one operation per LAT+1 cycles.
- Operand stability:
  - mul_a/mul_b change only on a handshake edge.
  - They remain stable from T+1 until the next handshake, including the capture edge.
- Requester behaviour:
  - A requester may drop req_valid before being granted; no grant is issued for it.
  - Operands are sampled only at the handshake, so requesters need not hold them afterwards.
- Fairness: after a grant to g, g has the lowest priority. ptr wraps from NREQ-1 to 0.
- Identical back-to-back operands are handled normally, with no dependence on operand change.
- Reset mid-BUSY aborts the in-flight operation: no rsp_valid is produced and ptr returns to 0.
- Width: rsp_y is the full unsigned 2*W product, no truncation. cnt is wide enough for LAT-1.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> all outputs 0 immediately, asynchronously. Release reset with no requests -> req_ready=0, busy=0.
- Single request, LAT=5: req_valid=4'b0100, A=3, B=5 in cycle T.
  - req_ready=4'b0100 in T; mul_a=3 and mul_b=5 from T+1.
  - rsp_valid=4'b0100 only in T+6, rsp_y=15.
- Continuous requests: all four requesters held valid continuously -> grants in order 0,1,2,3,0, one every 6 cycles.
  - Each rsp_valid is one-hot to the granted requester and rsp_y matches its operands.
- Max operands: A=B=0xFFFFFFFFFFFFFFFF -> rsp_y=0xFFFFFFFFFFFFFFFE0000000000000001.
- Back-to-back identical operands: requester 1 issues A=7, B=9 twice back-to-back -> two responses 63, at T+6 and T+12.
- Round-robin wrap: after a grant to requester 3, requesters 0 and 3 both valid -> requester 0 wins next.
- Reset mid-operation: rst_n pulsed low at T+3 of an operation -> no rsp_valid afterwards. A subsequent request from requester 2 alone with requester 0 idle is granted (ptr=0).
